mem_access_aligner: RTL and testbench

//  Sequential load/store alignment unit between the EX/MEM stage and the data memory port.

---
 rtl/mem_access_aligner.sv | 142 ++++++++++++++
 tb/tb_mem_access_aligner.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_aligner.sv
// Load/store alignment unit: turns byte-addressed B/H/W/D requests into word-aligned
// memory beats, splitting boundary-crossing accesses into two beats or faulting them.
module mem_access_aligner #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_fault,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [2:0] {IDLE, BEAT0, WAIT0, BEAT1, WAIT1, RESP} state_t;
  state_t state, state_nxt;

  logic [OW-1:0]     req_off;
  logic [3:0]        req_bytes;
  logic              req_split, req_fault, accept;

  logic              we_q, uns_q, split_q, fault_q;
  logic [1:0]        size_q;
  logic [OW-1:0]     off_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] wdata_q, rd0_q, rd1_q;

  logic [3:0]        bytes_q;
  logic [NB-1:0]     lane_mask, strb0, strb1;
  logic [DATA_W-1:0] wdata0, wdata1, keep, sign_mask, assembled, load_data;

  assign req_off   = req_addr[OW-1:0];
  assign req_bytes = 4'd1 << req_size;
  assign req_split = (32'(req_off) + 32'(req_bytes)) > NB;
  assign req_fault = (32'(req_bytes) > NB) || (req_split && !MISALIGN_SPLIT);
  assign accept    = req_valid && req_ready;

  // NOTE: only the state register is reset; the datapath registers below are not,
  // because every output they feed is gated by the state and reads 0 in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: sequential state is written with <= so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      off_q   <= req_off;
      base_q  <= {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
      wdata_q <= req_wdata;
      split_q <= req_split;
      fault_q <= req_fault;
    end
    if (state == WAIT0 && mem_rvalid) rd0_q <= mem_rdata;
    if (state == WAIT1 && mem_rvalid) rd1_q <= mem_rdata;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = req_fault ? RESP : BEAT0;
      BEAT0: if (mem_ready) state_nxt = !we_q ? WAIT0 : (split_q ? BEAT1 : RESP);
      WAIT0: if (mem_rvalid) state_nxt = split_q ? BEAT1 : RESP;
      BEAT1: if (mem_ready) state_nxt = we_q ? RESP : WAIT1;
      WAIT1: if (mem_rvalid) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane steering for both beats and load extraction/extension.
  always_comb begin
    bytes_q   = 4'd1 << size_q;
    lane_mask = {NB{1'b1}} >> (NB - 32'(bytes_q));
    strb0     = lane_mask << off_q;
    strb1     = lane_mask >> (NB - 32'(off_q));
    wdata0    = wdata_q << (8 * 32'(off_q));
    wdata1    = wdata_q >> (DATA_W - 8 * 32'(off_q));
    keep      = {DATA_W{1'b1}} >> (DATA_W - 8 * 32'(bytes_q));
    sign_mask = keep & ~(keep >> 1);
    assembled = (rd0_q >> (8 * 32'(off_q)))
              | (split_q ? (rd1_q << (DATA_W - 8 * 32'(off_q))) : '0);
    load_data = (assembled & keep)
              | ((!uns_q && |(assembled & sign_mask)) ? ~keep : '0);
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_fault = 1'b0;
    mem_valid  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wstrb  = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: req_ready = 1'b1;
      BEAT0: begin
        mem_valid = 1'b1;
        mem_we    = we_q;
        mem_addr  = base_q;
        mem_wstrb = we_q ? strb0 : '0;
        mem_wdata = we_q ? wdata0 : '0;
      end
      BEAT1: begin
        mem_valid = 1'b1;
        mem_we    = we_q;
        mem_addr  = base_q + ADDR_W'(NB);
        mem_wstrb = we_q ? strb1 : '0;
        mem_wdata = we_q ? wdata1 : '0;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_fault = fault_q;
        resp_rdata = (!we_q && !fault_q) ? load_data : '0;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mem_access_aligner.sv
// Directed bench for mem_access_aligner: 32-bit split, 32-bit fault-only and 64-bit
// instances driven from one linear sequence with hand-computed expectations.
module tb_mem_access_aligner;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  int          total = 0;
  int          bad   = 0;

  // Request fields shared by all instances; each has its own valid.
  logic        req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [63:0] req_wdata_c;
  logic        valid_a, valid_b, valid_c;

  logic        ready_a, resp_valid_a, fault_a, mem_valid_a, mem_ready_a, mem_we_a, rvalid_a;
  logic [31:0] rdata_a, mem_addr_a, mem_wdata_a, mrdata_a;
  logic [3:0]  mem_wstrb_a;

  logic        ready_b, resp_valid_b, fault_b, mem_valid_b, mem_we_b;
  logic [31:0] rdata_b, mem_addr_b, mem_wdata_b;
  logic [3:0]  mem_wstrb_b;

  logic        ready_c, resp_valid_c, fault_c, mem_valid_c, mem_we_c;
  logic [63:0] rdata_c, mem_wdata_c;
  logic [31:0] mem_addr_c;
  logic [7:0]  mem_wstrb_c;

  mem_access_aligner #(.DATA_W(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_a), .req_ready(ready_a), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_a), .resp_rdata(rdata_a), .resp_fault(fault_a),
    .mem_valid(mem_valid_a), .mem_ready(mem_ready_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wstrb(mem_wstrb_a), .mem_wdata(mem_wdata_a), .mem_rvalid(rvalid_a), .mem_rdata(mrdata_a));

  mem_access_aligner #(.DATA_W(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_b), .req_ready(ready_b), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_b), .resp_rdata(rdata_b), .resp_fault(fault_b),
    .mem_valid(mem_valid_b), .mem_ready(1'b1), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wstrb(mem_wstrb_b), .mem_wdata(mem_wdata_b), .mem_rvalid(1'b0), .mem_rdata(32'h0));

  mem_access_aligner #(.DATA_W(64), .ADDR_W(32), .MISALIGN_SPLIT(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_c), .req_ready(ready_c), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata_c),
    .resp_valid(resp_valid_c), .resp_rdata(rdata_c), .resp_fault(fault_c),
    .mem_valid(mem_valid_c), .mem_ready(1'b1), .mem_we(mem_we_c), .mem_addr(mem_addr_c),
    .mem_wstrb(mem_wstrb_c), .mem_wdata(mem_wdata_c), .mem_rvalid(1'b0), .mem_rdata(64'h0));

  // Results of the most recent run_* call.
  int          nbeats, resp_cyc;
  logic [63:0] b_addr[2], b_strb[2], b_wdata[2];
  logic        b_we[2];
  logic [63:0] r_rdata;
  logic        r_fault, saw_mem;
  logic [31:0] m100, m104;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    req_addr  = 32'hDEAD_BEEF;
    req_wdata = 32'hCAFE_F00D;
    req_wdata_c = 64'hCAFE_F00D_DEAD_BEEF;
    req_size  = 2'd1;
    req_unsigned = ~req_unsigned;
  endtask

  // Instance A with a two-word memory answering each read beat one cycle after acceptance.
  task automatic run_a(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    logic        pending;
    logic [31:0] paddr;
    pending = 1'b0; paddr = '0; nbeats = 0; resp_cyc = -1; r_rdata = 'x; r_fault = 1'bx;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    valid_a = 1'b1;
    for (int n = 1; n <= 20 && resp_cyc < 0; n++) begin
      @(negedge clk);
      valid_a = 1'b0;
      scramble();
      rvalid_a = 1'b0;
      if (pending) begin
        rvalid_a = 1'b1;
        mrdata_a = (paddr == 32'h104) ? m104 : m100;
        pending  = 1'b0;
      end
      if (mem_valid_a && mem_ready_a && nbeats < 2) begin
        b_addr[nbeats] = 64'(mem_addr_a); b_strb[nbeats] = 64'(mem_wstrb_a);
        b_wdata[nbeats] = 64'(mem_wdata_a); b_we[nbeats] = mem_we_a;
        if (!mem_we_a) begin pending = 1'b1; paddr = mem_addr_a; end
        nbeats++;
      end
      if (resp_valid_a) begin resp_cyc = n; r_rdata = 64'(rdata_a); r_fault = fault_a; end
    end
    @(negedge clk);
    rvalid_a = 1'b0;
    check("a_resp_single_cycle", resp_valid_a, 1'b0);
  endtask

  // Instance B (no splitting); watches a fixed window so any stray beat is seen.
  task automatic run_b(input logic we, input logic [1:0] size, input logic [31:0] addr);
    saw_mem = 1'b0; resp_cyc = -1; r_rdata = 'x; r_fault = 1'bx;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = 1'b0; req_addr = addr; req_wdata = 32'h1357_9BDF;
    valid_b = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      valid_b = 1'b0;
      scramble();
      if (mem_valid_b) saw_mem = 1'b1;
      if (resp_valid_b && resp_cyc < 0) begin
        resp_cyc = n; r_rdata = 64'(rdata_b); r_fault = fault_b;
      end
    end
  endtask

  // Instance C (64-bit word) stores.
  task automatic run_c(input logic [1:0] size, input logic [31:0] addr, input logic [63:0] wdata);
    nbeats = 0; resp_cyc = -1; r_fault = 1'bx;
    @(negedge clk);
    req_we = 1'b1; req_size = size; req_unsigned = 1'b0; req_addr = addr; req_wdata_c = wdata;
    valid_c = 1'b1;
    for (int n = 1; n <= 20 && resp_cyc < 0; n++) begin
      @(negedge clk);
      valid_c = 1'b0;
      scramble();
      if (mem_valid_c && nbeats < 2) begin
        b_addr[nbeats] = 64'(mem_addr_c); b_strb[nbeats] = 64'(mem_wstrb_c);
        b_wdata[nbeats] = mem_wdata_c; b_we[nbeats] = mem_we_c;
        nbeats++;
      end
      if (resp_valid_c) begin resp_cyc = n; r_fault = fault_c; end
    end
  endtask

  initial begin
    rst_n = 1'b0; valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0;
    req_wdata = '0; req_wdata_c = '0;
    mem_ready_a = 1'b1; rvalid_a = 1'b0; mrdata_a = '0; m100 = '0; m104 = '0;
    repeat (2) @(negedge clk);

    check("rst_req_ready",  ready_a, 1'b1);
    check("rst_mem_valid",  mem_valid_a, 1'b0);
    check("rst_mem_we",     mem_we_a, 1'b0);
    check("rst_mem_addr",   mem_addr_a, 32'h0);
    check("rst_mem_wstrb",  mem_wstrb_a, 4'h0);
    check("rst_mem_wdata",  mem_wdata_a, 32'h0);
    check("rst_resp_valid", resp_valid_a, 1'b0);
    check("rst_resp_rdata", rdata_a, 32'h0);
    check("rst_resp_fault", fault_a, 1'b0);
    rst_n = 1'b1;

    // SW 0x100, aligned single beat
    run_a(1'b1, 2'd2, 1'b0, 32'h100, 32'h1234_5678);
    check("sw_nbeats", 64'(nbeats), 64'd1);
    check("sw_addr",   b_addr[0], 64'h100);
    check("sw_strb",   b_strb[0], 64'hF);
    check("sw_wdata",  b_wdata[0], 64'h1234_5678);
    check("sw_we",     b_we[0], 1'b1);
    check("sw_lat",    64'(resp_cyc), 64'd2);
    check("sw_rdata",  r_rdata, 64'h0);
    check("sw_fault",  r_fault, 1'b0);

    // SB 0x103 into top lane
    run_a(1'b1, 2'd0, 1'b0, 32'h103, 32'h0000_00AB);
    check("sb_nbeats", 64'(nbeats), 64'd1);
    check("sb_addr",   b_addr[0], 64'h100);
    check("sb_strb",   b_strb[0], 64'h8);
    check("sb_wdata",  b_wdata[0], 64'hAB00_0000);

    // SH 0x103 crosses the word boundary
    run_a(1'b1, 2'd1, 1'b0, 32'h103, 32'h0000_BEEF);
    check("sh_nbeats", 64'(nbeats), 64'd2);
    check("sh_addr0",  b_addr[0], 64'h100);
    check("sh_strb0",  b_strb[0], 64'h8);
    check("sh_wdata0", b_wdata[0], 64'hEF00_0000);
    check("sh_addr1",  b_addr[1], 64'h104);
    check("sh_strb1",  b_strb[1], 64'h1);
    check("sh_wdata1", b_wdata[1], 64'h0000_00BE);
    check("sh_lat",    64'(resp_cyc), 64'd3);

    // LW 0x102 split load
    m100 = 32'h4433_2211; m104 = 32'h8877_6655;
    run_a(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
    check("lw_nbeats", 64'(nbeats), 64'd2);
    check("lw_we0",    b_we[0], 1'b0);
    check("lw_strb0",  b_strb[0], 64'h0);
    check("lw_addr1",  b_addr[1], 64'h104);
    check("lw_rdata",  r_rdata, 64'h6655_4433);
    check("lw_fault",  r_fault, 1'b0);

    // Halfword/byte extraction and extension
    m100 = 32'h80FF_1234; m104 = 32'h0;
    run_a(1'b0, 2'd1, 1'b0, 32'h102, 32'h0);
    check("lh_rdata",  r_rdata, 64'hFFFF_80FF);
    check("lh_lat",    64'(resp_cyc), 64'd3);
    run_a(1'b0, 2'd1, 1'b1, 32'h102, 32'h0);
    check("lhu_rdata", r_rdata, 64'h0000_80FF);
    run_a(1'b0, 2'd0, 1'b0, 32'h101, 32'h0);
    check("lb_rdata",  r_rdata, 64'h0000_0012);
    run_a(1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
    check("lb_neg_rdata", r_rdata, 64'hFFFF_FF80);

    // Doubleword on a 32-bit unit faults even when splitting is allowed
    run_a(1'b1, 2'd3, 1'b0, 32'h100, 32'h0);
    check("a_sd_fault",  r_fault, 1'b1);
    check("a_sd_nbeats", 64'(nbeats), 64'd0);
    check("a_sd_lat",    64'(resp_cyc), 64'd1);

    // Splitting disabled: misaligned LW faults without a memory beat
    run_b(1'b0, 2'd2, 32'h101);
    check("ns_lw_fault", r_fault, 1'b1);
    check("ns_lw_rdata", r_rdata, 64'h0);
    check("ns_lw_nomem", saw_mem, 1'b0);
    check("ns_lw_lat",   64'(resp_cyc), 64'd1);
    run_b(1'b1, 2'd3, 32'h100);
    check("ns_sd_fault", r_fault, 1'b1);
    check("ns_sd_nomem", saw_mem, 1'b0);
    run_b(1'b1, 2'd2, 32'h104);
    check("ns_sw_fault", r_fault, 1'b0);
    check("ns_sw_mem",   saw_mem, 1'b1);
    check("ns_sw_lat",   64'(resp_cyc), 64'd2);

    // 64-bit word: SD 0x0C splits F0 / 0F
    run_c(2'd3, 32'h0C, 64'h1122_3344_5566_7788);
    check("d64_nbeats", 64'(nbeats), 64'd2);
    check("d64_addr0",  b_addr[0], 64'h08);
    check("d64_strb0",  b_strb[0], 64'hF0);
    check("d64_wdata0", b_wdata[0], 64'h5566_7788_0000_0000);
    check("d64_addr1",  b_addr[1], 64'h10);
    check("d64_strb1",  b_strb[1], 64'h0F);
    check("d64_wdata1", b_wdata[1], 64'h0000_0000_1122_3344);
    check("d64_fault",  r_fault, 1'b0);

    // Back-pressure: beat outputs hold while mem_ready is low
    mem_ready_a = 1'b0;
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0; req_addr = 32'h103; req_wdata = 32'hBEEF;
    valid_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid_a = 1'b0;
      scramble();
      check("stall_valid", mem_valid_a, 1'b1);
      check("stall_addr",  mem_addr_a, 32'h100);
      check("stall_strb",  mem_wstrb_a, 4'h8);
      check("stall_wdata", mem_wdata_a, 32'hEF00_0000);
    end
    mem_ready_a = 1'b1;
    @(negedge clk);
    check("stall_beat1_addr",  mem_addr_a, 32'h104);
    check("stall_beat1_strb",  mem_wstrb_a, 4'h1);
    check("stall_beat1_wdata", mem_wdata_a, 32'h0000_00BE);
    @(negedge clk);
    check("stall_resp", resp_valid_a, 1'b1);
    @(negedge clk);

    // Reset while waiting for load data abandons the transaction
    @(negedge clk);
    req_we = 1'b0; req_size = 2'd2; req_addr = 32'h100; valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    check("rw_beat0", mem_valid_a, 1'b1);
    @(negedge clk);
    check("rw_wait0_no_mem", mem_valid_a, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rw_ready",  ready_a, 1'b1);
    check("rw_noresp", resp_valid_a, 1'b0);
    rvalid_a = 1'b1; mrdata_a = 32'h5A5A_5A5A;
    @(negedge clk);
    rvalid_a = 1'b0;
    check("rw_stale_noresp", resp_valid_a, 1'b0);
    check("rw_stale_nomem",  mem_valid_a, 1'b0);
    check("rw_stale_ready",  ready_a, 1'b1);

    run_a(1'b1, 2'd2, 1'b0, 32'h108, 32'hA5A5_A5A5);
    check("post_sw_addr",  b_addr[0], 64'h108);
    check("post_sw_strb",  b_strb[0], 64'hF);
    check("post_sw_wdata", b_wdata[0], 64'hA5A5_A5A5);
    check("post_sw_lat",   64'(resp_cyc), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
